keypad_decoder: RTL and testbench

//   Downstream stage of the 4x4 keypad column scanner. Takes the scanner's held

---
 rtl/keypad_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_keypad_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder.sv
// keypad_decoder
//   Debounces the 4x4 keypad scanner's one-hot {row, col} pair and turns each
//   physical press into a 4-bit key code {row_idx, col_idx}. The codes are
//   queued in a small FIFO that the consumer reads through a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   row_pressed   one-hot row of the pressed key, 0 = none
//   col_pressed   one-hot column of the pressed key, 0 = none
//   key_valid     FIFO head holds a key event
//   key_code      FIFO head code {row_idx[1:0], col_idx[1:0]}; 0 when empty
//   key_ready     consumer accepts the head
//   key_held      a debounced valid key is currently down
//   multi_err     sticky: a debounced pair was neither none nor one-hot/one-hot
//   overflow      sticky: an event was dropped because the FIFO was full
//   err_clr       synchronous clear of multi_err and overflow
//   state_dbg     current FSM state (0 = IDLE, 1 = HELD)
//
// Handshake: an event transfers on every rising clk edge where
// key_valid && key_ready. key_valid stays high and key_code stays constant
// until that transfer happens; key_ready may be asserted freely and has no
// effect while key_valid is low.

module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_pressed,
  input  logic [3:0] col_pressed,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       multi_err,
  output logic       overflow,
  input  logic       err_clr,
  output logic       state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Registered state
  logic [7:0]    pair_q,      pair_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          handled_q,   handled_d;
  state_t        state_q,     state_d;
  logic          key_held_q,  key_held_d;
  logic [3:0]    last_code_q, last_code_d;
  logic          multi_err_q, multi_err_d;
  logic          overflow_q,  overflow_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW:0]   count_q,     count_d;

  // Combinational helpers
  logic [7:0] pair_in;
  logic       pair_changed;
  logic       stable;
  logic       act;
  logic       pair_none;
  logic       pair_valid;
  logic [3:0] code_cur;
  logic       push_req;
  logic       multi_set;
  logic       fifo_full;
  logic       fifo_empty;
  logic       do_pop;
  logic       do_push;
  logic       ovf_set;

  // Debounce: the counter restarts whenever the freshly registered pair differs
  // from the previous one and saturates at CNT_MAX. handled_q marks that the
  // FSM has already acted on the current stable pair, so a long hold is
  // processed exactly once.
  always_comb begin
    pair_in      = {row_pressed, col_pressed};
    pair_changed = (pair_in != pair_q);
    pair_d       = pair_in;
    cnt_d        = cnt_q;
    if (pair_changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    stable     = (cnt_q == CNT_MAX);
    act        = stable && !handled_q;
    handled_d  = handled_q;
    if (pair_changed) begin
      handled_d = 1'b0;
    end else if (act) begin
      handled_d = 1'b1;
    end
    pair_none  = (pair_q == 8'd0);
    pair_valid = is_onehot(pair_q[7:4]) && is_onehot(pair_q[3:0]);
    code_cur   = {enc(pair_q[7:4]), enc(pair_q[3:0])};
  end

  // FSM next state. key_held_q also serves as "last_code_q is meaningful":
  // HELD entered through a bad pair has no reference code, so the first valid
  // pair seen afterwards is always reported.
  always_comb begin
    state_d     = state_q;
    key_held_d  = key_held_q;
    last_code_d = last_code_q;
    push_req    = 1'b0;
    multi_set   = 1'b0;
    if (act) begin
      case (state_q)
        S_IDLE: begin
          if (pair_valid) begin
            push_req    = 1'b1;
            key_held_d  = 1'b1;
            last_code_d = code_cur;
            state_d     = S_HELD;
          end else if (!pair_none) begin
            multi_set = 1'b1;
            state_d   = S_HELD;
          end
        end
        S_HELD: begin
          if (pair_none) begin
            key_held_d = 1'b0;
            state_d    = S_IDLE;
          end else if (pair_valid) begin
            if (!key_held_q || (code_cur != last_code_q)) begin
              push_req    = 1'b1;
              key_held_d  = 1'b1;
              last_code_d = code_cur;
            end
          end else begin
            multi_set = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO and sticky flags. A push into a full FIFO still succeeds when the
  // head is being popped in the same cycle.
  always_comb begin
    fifo_full  = (count_q == DEPTH_V);
    fifo_empty = (count_q == '0);
    do_pop     = key_ready && !fifo_empty;
    do_push    = push_req && (!fifo_full || do_pop);
    ovf_set    = push_req && fifo_full && !do_pop;

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = code_cur;
    end
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A set event in the same cycle as err_clr wins.
    multi_err_d = multi_set ? 1'b1 : (err_clr ? 1'b0 : multi_err_q);
    overflow_d  = ovf_set   ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q      <= '0;
      cnt_q       <= '0;
      handled_q   <= 1'b0;
      state_q     <= S_IDLE;
      key_held_q  <= 1'b0;
      last_code_q <= '0;
      multi_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pair_q      <= pair_d;
      cnt_q       <= cnt_d;
      handled_q   <= handled_d;
      state_q     <= state_d;
      key_held_q  <= key_held_d;
      last_code_q <= last_code_d;
      multi_err_q <= multi_err_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign key_valid = !fifo_empty;
  assign key_code  = fifo_empty ? 4'd0 : mem_q[rd_ptr_q];
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_decoder.sv
module tb_keypad_decoder;

  localparam int D = 64;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_pressed = 4'd0;
  logic [3:0] col_pressed = 4'd0;
  logic       key_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_err;
  logic       overflow;
  logic       state_dbg;

  always #5 clk = ~clk;

  keypad_decoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_pressed (row_pressed),
    .col_pressed (col_pressed),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .multi_err   (multi_err),
    .overflow    (overflow),
    .err_clr     (err_clr),
    .state_dbg   (state_dbg)
  );

  // Scoreboard
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int evt_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and
  // ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      evt_cnt++;
      check("evt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("evt_code", key_code, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pair(input logic [3:0] r, input logic [3:0] c);
    row_pressed = r;
    col_pressed = c;
  endtask

  task automatic release_key();
    drive_pair(4'd0, 4'd0);
    step($urandom_range(75, 95));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    logic [3:0] rows  [5];
    logic [3:0] cols  [5];
    logic [3:0] codes [5];
    rows  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    cols  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    codes = '{4'h0,    4'h5,    4'hA,    4'hF,    4'h6};

    // Reset state
    step(3);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_multi", multi_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    step(5);

    // 1. Reset mid-press
    key_ready = 1'b0;
    drive_pair(4'b0010, 4'b0100);
    step(90);
    check("t1_valid_before", key_valid, 1);
    check("t1_held_before", key_held, 1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", key_valid, 0);
    check("t1_rst_code", key_code, 0);
    check("t1_rst_held", key_held, 0);
    check("t1_rst_multi", multi_err, 0);
    check("t1_rst_ovf", overflow, 0);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(4'h6);
    key_ready = 1'b1;
    wait_drain(200);
    step(30);
    check("t1_evt_cnt", evt_cnt, 1);
    release_key();
    check("t1_held_released", key_held, 0);

    // 2. Single press, latency, no repeat
    key_ready = 1'b0;
    base = evt_cnt;
    drive_pair(4'b0001, 4'b1000);
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!key_valid && lat < 200);
    check("t2_latency", (lat >= D + 1) && (lat <= D + 2), 1);
    exp_q.push_back(4'h3);
    key_ready = 1'b1;
    step(200 - lat);
    check("t2_held", key_held, 1);
    wait_drain(10);
    check("t2_one_evt", evt_cnt - base, 1);
    release_key();
    check("t2_held_released", key_held, 0);
    check("t2_no_repeat", evt_cnt - base, 1);

    // 3. Bounce then settle
    base = evt_cnt;
    for (int i = 0; i < 30; i++) begin
      drive_pair((i % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0001);
      step(10);
    end
    check("t3_no_evt_bounce", evt_cnt - base, 0);
    check("t3_no_multi", multi_err, 0);
    drive_pair(4'b0010, 4'b0001);
    exp_q.push_back(4'h4);
    step(100);
    wait_drain(10);
    check("t3_one_evt", evt_cnt - base, 1);
    check("t3_held", key_held, 1);
    release_key();

    // 4. FIFO fill and overflow
    key_ready = 1'b0;
    base = evt_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_pair(rows[i], cols[i]);
      if (i < 4) exp_q.push_back(codes[i]);
      step(80);
      release_key();
    end
    check("t4_ovf", overflow, 1);
    check("t4_valid", key_valid, 1);
    check("t4_head", key_code, 4'h0);
    pulse_clr();
    check("t4_ovf_clr", overflow, 0);
    key_ready = 1'b1;
    wait_drain(20);
    step(2);
    check("t4_empty", key_valid, 0);
    check("t4_four_evt", evt_cnt - base, 4);

    // 5. Multi-hot pair
    base = evt_cnt;
    drive_pair(4'b0011, 4'b0100);
    step(80);
    check("t5_multi", multi_err, 1);
    check("t5_no_push", key_valid, 0);
    release_key();
    check("t5_multi_sticky", multi_err, 1);
    check("t5_no_evt", evt_cnt - base, 0);
    pulse_clr();
    check("t5_multi_clr", multi_err, 0);

    // 6. Rollover without release
    base = evt_cnt;
    drive_pair(4'b0001, 4'b0010);
    exp_q.push_back(4'h1);
    step(80);
    drive_pair(4'b0001, 4'b0100);
    exp_q.push_back(4'h2);
    step(80);
    wait_drain(10);
    check("t6_two_evt", evt_cnt - base, 2);
    check("t6_held", key_held, 1);
    release_key();
    check("t6_held_released", key_held, 0);
    check("t6_no_extra", evt_cnt - base, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
